// File: rtl/dsp19x2_lane_accumulator.sv
// dsp19x2_lane_accumulator
// Per-lane frame accumulator for the packed dual-lane DSP19x2 result word.
// Each 19-bit lane is summed independently over a frame of dump_len samples
// with saturating arithmetic. Completed sums are presented through a
// single-entry valid/ready output register.
// Build option: define DSP19X2_ACC_SIGNED_EN to treat the lanes as two's
// complement (sign extension, symmetric saturation). When it is undefined,
// lanes are unsigned and saturate at the top of the range only.
module dsp19x2_lane_accumulator #(
    parameter int LANE_W = 19,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*LANE_W-1:0]   z_in,
    input  logic [CNT_W-1:0]      dump_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*ACC_W-1:0]    acc_out,
    output logic [1:0]            overflow
);

    typedef enum logic {ST_IDLE, ST_ACCUM} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      len_q, len_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ACC_W-1:0]      acc0_q, acc0_d;
    logic [ACC_W-1:0]      acc1_q, acc1_d;
    logic [1:0]            flg_q, flg_d;
    logic                  out_valid_q, out_valid_d;
    logic [2*ACC_W-1:0]    acc_out_q, acc_out_d;
    logic [1:0]            ovf_q, ovf_d;

    logic [CNT_W-1:0]      len_eff;
    logic                  final_smp;
    logic                  accept;
    logic [ACC_W:0]        sum0;
    logic [ACC_W:0]        sum1;

    // Saturating add of one lane into its accumulator.
    // Result is {saturated_flag, clamped_sum}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  acc,
                                               input logic [LANE_W-1:0] lane);
`ifdef DSP19X2_ACC_SIGNED_EN
        logic signed [ACC_W:0] s;
        s = $signed({acc[ACC_W-1], acc})
          + $signed({{(ACC_W+1-LANE_W){lane[LANE_W-1]}}, lane});
        // The exact sum fits ACC_W bits only when its two top bits agree.
        if (s[ACC_W] != s[ACC_W-1]) begin
            if (s[ACC_W])
                sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
            else
                sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            sat_add = {1'b0, s[ACC_W-1:0]};
        end
`else
        logic [ACC_W:0] u;
        u = {1'b0, acc} + {{(ACC_W+1-LANE_W){1'b0}}, lane};
        if (u[ACC_W])
            sat_add = {1'b1, {ACC_W{1'b1}}};
        else
            sat_add = {1'b0, u[ACC_W-1:0]};
`endif
    endfunction

    // Handshake qualifiers: frame length in force, last-sample detect, backpressure.
    always_comb begin
        len_eff   = len_q;
        final_smp = 1'b0;
        if (state_q == ST_IDLE) begin
            len_eff   = (dump_len == '0) ? CNT_ONE : dump_len;
            final_smp = (len_eff == CNT_ONE);
        end else begin
            final_smp = (cnt_q == len_q - CNT_ONE);
        end
        // Only the frame-completing sample has to wait for a free output slot.
        in_ready = !(final_smp && out_valid_q && !out_ready);
        accept   = in_valid && in_ready;
        sum0     = sat_add(acc0_q, z_in[LANE_W-1:0]);
        sum1     = sat_add(acc1_q, z_in[2*LANE_W-1:LANE_W]);
    end

    // Next-state: frame FSM, lane accumulators and the output register.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        acc0_d      = acc0_q;
        acc1_d      = acc1_q;
        flg_d       = flg_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        ovf_d       = ovf_q;

        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;

        if (accept) begin
            if (final_smp) begin
                // Completion overrides a same-edge transfer so no frame is lost.
                acc_out_d   = {sum1[ACC_W-1:0], sum0[ACC_W-1:0]};
                ovf_d       = {flg_q[1] | sum1[ACC_W], flg_q[0] | sum0[ACC_W]};
                out_valid_d = 1'b1;
                acc0_d      = '0;
                acc1_d      = '0;
                flg_d       = 2'b00;
                cnt_d       = '0;
                state_d     = ST_IDLE;
            end else begin
                acc0_d      = sum0[ACC_W-1:0];
                acc1_d      = sum1[ACC_W-1:0];
                flg_d       = {flg_q[1] | sum1[ACC_W], flg_q[0] | sum0[ACC_W]};
                cnt_d       = cnt_q + CNT_ONE;
                len_d       = len_eff;
                state_d     = ST_ACCUM;
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            len_q       <= CNT_ONE;
            cnt_q       <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            flg_q       <= 2'b00;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            ovf_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            flg_q       <= flg_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_dsp19x2_lane_accumulator.sv
// Testbench for dsp19x2_lane_accumulator: directed scenarios plus a random
// phase, all checked against a frame-level reference model.
// Honours DSP19X2_ACC_SIGNED_EN the same way as the design.
module tb_dsp19x2_lane_accumulator;

    localparam int LANE_W = 19;
    localparam int ACC_W  = 24;
    localparam int CNT_W  = 8;

`ifdef DSP19X2_ACC_SIGNED_EN
    localparam longint SMAX = (64'sd1 <<< (ACC_W-1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (ACC_W-1));
`else
    localparam longint SMAX = (64'sd1 <<< ACC_W) - 1;
    localparam longint SMIN = 0;
`endif

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [2*LANE_W-1:0]  z_in;
    logic [CNT_W-1:0]     dump_len;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*ACC_W-1:0]   acc_out;
    logic [1:0]           overflow;

    int checks   = 0;
    int failures = 0;
    int n_xfer   = 0;

    typedef struct {
        logic [2*ACC_W-1:0] acc;
        logic [1:0]         ovf;
    } frame_t;

    frame_t exp_q[$];

    // Reference model state: one partial frame, sums kept as plain integers.
    bit     m_active = 0;
    int     m_len    = 1;
    int     m_cnt    = 0;
    longint m_s0     = 0;
    longint m_s1     = 0;
    logic [1:0] m_f  = 2'b00;

    dsp19x2_lane_accumulator #(
        .LANE_W(LANE_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .z_in     (z_in),
        .dump_len (dump_len),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .acc_out  (acc_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic longint lane_val(input logic [LANE_W-1:0] l);
        longint v;
        v = longint'({45'd0, l});
`ifdef DSP19X2_ACC_SIGNED_EN
        if (l[LANE_W-1]) v = v - (64'sd1 <<< LANE_W);
`endif
        return v;
    endfunction

    function automatic longint clamp(input longint v, output logic hit);
        hit = 1'b0;
        if (v > SMAX) begin v = SMAX; hit = 1'b1; end
        else if (v < SMIN) begin v = SMIN; hit = 1'b1; end
        return v;
    endfunction

    task automatic model_accept(input logic [2*LANE_W-1:0] z, input logic [CNT_W-1:0] dl);
        logic h0, h1;
        frame_t f;
        if (!m_active) begin
            m_len    = (dl == 0) ? 1 : int'(dl);
            m_cnt    = 0;
            m_s0     = 0;
            m_s1     = 0;
            m_f      = 2'b00;
            m_active = 1;
        end
        m_s0 = clamp(m_s0 + lane_val(z[LANE_W-1:0]), h0);
        m_s1 = clamp(m_s1 + lane_val(z[2*LANE_W-1:LANE_W]), h1);
        m_f  = m_f | {h1, h0};
        m_cnt++;
        if (m_cnt == m_len) begin
            f.acc = {m_s1[ACC_W-1:0], m_s0[ACC_W-1:0]};
            f.ovf = m_f;
            exp_q.push_back(f);
            m_active = 0;
        end
    endtask

    // Monitor: compare outputs to the model mid-cycle, then apply the
    // transfer and accept that will happen on the coming rising edge.
    always @(negedge clk) begin
        bit last;
        int eff;
        if (reset) begin
            m_active = 0;
            exp_q.delete();
        end else begin
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
            if (out_valid && exp_q.size() != 0) begin
                chk("acc_out", 64'(acc_out), 64'(exp_q[0].acc));
                chk("overflow", 64'(overflow), 64'(exp_q[0].ovf));
            end
            eff  = (dump_len == 0) ? 1 : int'(dump_len);
            last = m_active ? (m_cnt == m_len - 1) : (eff == 1);
            chk("in_ready", 64'(in_ready), 64'(!(last && exp_q.size() != 0 && !out_ready)));
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                n_xfer++;
            end
            if (in_valid && in_ready) model_accept(z_in, dump_len);
        end
    end

    // Present one sample and hold it until the block accepts it.
    task automatic send(input logic [2*LANE_W-1:0] z);
        bit ok;
        ok       = 0;
        in_valid = 1'b1;
        z_in     = z;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $error("FAIL send_timeout observed=%0h expected=%0h", in_ready, 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int x0;
        bit took;
        reset     = 1'b1;
        in_valid  = 1'b0;
        z_in      = '0;
        dump_len  = '0;
        out_ready = 1'b1;
        cycles(3);
        reset = 1'b0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_acc_out", 64'(acc_out), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // Basic frame of four samples.
        dump_len = 8'd4;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("basic_pre_valid", 64'(out_valid), 64'(0));
            send(38'd1021);
        end
        chk("basic_valid", 64'(out_valid), 64'(1));
        chk("basic_acc", 64'(acc_out), 64'({24'd0, 24'd4084}));
        chk("basic_ovf", 64'(overflow), 64'(0));
        cycles(2);

        // Saturation over a long frame, then a clean single-sample frame.
        dump_len = 8'd40;
        for (int i = 0; i < 40; i++) begin
`ifdef DSP19X2_ACC_SIGNED_EN
            send({19'h3FFFF, 19'h3FFFF});
`else
            send({19'h7FFFF, 19'h7FFFF});
`endif
        end
`ifdef DSP19X2_ACC_SIGNED_EN
        chk("sat_acc", 64'(acc_out), 64'({24'h7FFFFF, 24'h7FFFFF}));
`else
        chk("sat_acc", 64'(acc_out), 64'({24'hFFFFFF, 24'hFFFFFF}));
`endif
        chk("sat_ovf", 64'(overflow), 64'(2'b11));
        dump_len = 8'd1;
        send({19'd7, 19'd5});
        chk("after_sat_acc", 64'(acc_out), 64'({24'd7, 24'd5}));
        chk("after_sat_ovf", 64'(overflow), 64'(0));
        cycles(2);

        // Backpressure: held output blocks only the frame-completing sample.
        x0        = n_xfer;
        out_ready = 1'b0;
        dump_len  = 8'd2;
        send(38'd1);
        send(38'd1);
        send(38'd1);
        in_valid = 1'b1;
        z_in     = 38'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_hold_valid", 64'(out_valid), 64'(1));
            chk("bp_hold_acc", 64'(acc_out), 64'({24'd0, 24'd2}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(38'd1);
        send(38'd1);
        send(38'd1);
        cycles(3);
        chk("bp_frames", 64'(n_xfer - x0), 64'(3));

        // dump_len of zero behaves as a one-sample frame.
        dump_len = 8'd0;
        send({19'd9, 19'd0});
        chk("len0_valid", 64'(out_valid), 64'(1));
        chk("len0_acc", 64'(acc_out), 64'({24'd9, 24'd0}));
        cycles(2);

        // Reset mid-frame with a pending output.
        out_ready = 1'b0;
        dump_len  = 8'd1;
        send({19'd0, 19'd3});
        dump_len = 8'd8;
        for (int i = 0; i < 3; i++) send(38'd1);
        reset = 1'b1;
        cycles(1);
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_acc", 64'(acc_out), 64'(0));
        chk("midrst_ovf", 64'(overflow), 64'(0));
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(38'd1);
        chk("fresh_acc", 64'(acc_out), 64'({24'd0, 24'd8}));
        cycles(2);

`ifdef DSP19X2_ACC_SIGNED_EN
        // Signed lanes: three samples of -1.
        dump_len = 8'd3;
        for (int i = 0; i < 3; i++) send({19'd0, 19'h7FFFF});
        chk("signed_acc", 64'(acc_out), 64'({24'd0, 24'hFFFFFD}));
        chk("signed_ovf", 64'(overflow), 64'(0));
        cycles(2);
`endif

        // Random traffic with random backpressure; the monitor checks it all.
        took = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                z_in[LANE_W-1:0]        = ($urandom_range(0, 3) == 0) ? 19'h7FFFF : 19'($urandom);
                z_in[2*LANE_W-1:LANE_W] = ($urandom_range(0, 3) == 0) ? 19'h7FFFF : 19'($urandom);
            end
            dump_len  = ($urandom_range(0, 9) == 0) ? 8'd40 : 8'($urandom_range(0, 12));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles(5);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dsp19x2_lane_accumulator.md
Name: dsp19x2_lane_accumulator

Overview:
Downstream consumer of the dual-lane DSP19x2 add/multiply stage. Takes the packed 38-bit result word (two 19-bit lanes) and accumulates each lane independently over a programmable frame length. Presents per-lane saturated sums through a registered valid/ready output port. Sits between the DSP19x2 output and the frame-level result bus.

Parameters:
LANE_W, 19, width of each input lane; z_in is 2*LANE_W bits
ACC_W, 24, width of each lane accumulator and output lane (ACC_W > LANE_W)
CNT_W, 8, width of the frame-length field and the sample counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  z_in holds a valid DSP result
in_ready  output  1  block accepts z_in this cycle
z_in  input  2*LANE_W  {lane1 = z_in[37:19], lane0 = z_in[18:0]}
dump_len  input  CNT_W  samples per frame; sampled at frame start; 0 is treated as 1
out_valid  output  1  acc_out/overflow hold a completed frame
out_ready  input  1  downstream takes the frame
acc_out  output  2*ACC_W  {lane1 sum, lane0 sum}
overflow  output  2  per-lane sticky saturation flag for the presented frame

Behaviour:
- Reset, clk and reset only; synchronous, active-high:
  - out_valid=0, acc_out=0, overflow=0.
  - Accumulators and counter cleared; state=IDLE.
  - in_ready=1 on the first cycle after reset deasserts.
- Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
- FSM states:
  - IDLE: no partial frame. On accept, latch len = (dump_len==0 ? 1 : dump_len), add the sample, count=1, go to ACCUM. If len==1, the frame completes on this same edge.
  - ACCUM: each accept adds the lanes and increments count. Dump_len is ignored mid-frame.
- Completion: the edge that accepts sample number len:
  - loads acc_out with accumulator+sample and overflow with the final flags;
  - sets out_valid=1 on the next cycle (latency 1 clock from the final accept);
  - clears accumulators and count on the same edge; state returns to IDLE.
  - The next frame's first sample may be accepted in the following cycle.
- Lane arithmetic:
  - Unsigned; lanes zero-extended to ACC_W.
  - On sum > 2^ACC_W-1, clamp to 2^ACC_W-1 and set that lane's sticky flag.
  - Flags clear at frame start.
- Output register: single entry. out_valid holds, and acc_out/overflow stay stable, until transfer. out_valid drops after transfer unless a new frame completes on the same edge.
- Backpressure rule:
  - in_ready = !(state==ACCUM && count==len-1 && out_valid && !out_ready). Same check applies in IDLE when len==1.
  - The combinational out_ready->in_ready path is permitted.
  - Non-final samples are accepted while the output is held.
- Simultaneous transfer and completion on one edge: new frame loads the output; out_valid stays 1; no frame lost.
- in_valid with in_ready=0: sample not consumed; upstream holds it.
- Reset mid-frame: partial sums discarded, any pending output dropped, out_valid=0.

Optional Feature:
DSP19X2_ACC_SIGNED_EN
- Defined: lanes are two's complement. Sign-extend each lane to ACC_W. Saturate at +2^(ACC_W-1)-1 and -2^(ACC_W-1); the flag sets on either clamp.
- Undefined: unsigned zero-extend, upper clamp only, as above.

Test Plan:
- Basic frame. Stimulus: dump_len=4; four accepts of lane0=1021, lane1=0 (z_in=38'd1021); out_ready=1. Required: out_valid high exactly 1 cycle after the 4th accept; acc_out lane0=4084, lane1=0; overflow=0.
- Saturation, unsigned. Stimulus: dump_len=40; all samples lane0=lane1=524287. Required: both lanes=16777215; overflow=2'b11. Next frame with dump_len=1, lanes=5/7. Required: acc_out lane0=5, lane1=7; overflow=0.
- Backpressure. Stimulus: dump_len=2, out_ready=0, six back-to-back samples of lane0=1. Required: frame 1 (lane0=2) held stable; sample 3 accepted; in_ready=0 on sample 4. Release out_ready. Required: frames 2 and 3 delivered, each lane0=2; no sample lost or duplicated.
- dump_len=0. Stimulus: single sample lane1=9. Required: frame of length 1; acc_out lane1=9 one cycle later.
- Reset mid-frame. Stimulus: dump_len=8; assert reset after 3 accepts. Required: out_valid=0, acc_out=0. Then a fresh 8-sample frame of lane0=1. Required: lane0=8, with no carry-over from the aborted frame.
- Signed build, DSP19X2_ACC_SIGNED_EN defined. Stimulus: dump_len=3, lane0=19'h7FFFF (-1) each sample. Required: lane0 sum = -3 (24'hFFFFFD); overflow=0.
